// File: rtl/mem_port_arbiter.sv
// Merges several cache line-transfer ports onto one shared slow-memory port.
// One transaction in flight; round-robin or fixed-priority selection.
module mem_port_arbiter #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned AW       = 28,
    parameter int unsigned DW       = 128,
    parameter int unsigned ARB_MODE = 0,
    localparam int unsigned GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_read,
    input  logic [NUM_CH-1:0]    ch_write,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    output logic [DW-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     ch_rdata_q, ch_rdata_d;
    logic [NUM_CH-1:0] ch_ready_q, ch_ready_d;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [GW-1:0]     winner;
    logic [AW-1:0]     addr_arr  [NUM_CH];
    logic [DW-1:0]     wdata_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_addr[g*AW +: AW];
        assign wdata_arr[g] = ch_wdata[g*DW +: DW];
    end

    assign req     = ch_read | ch_write;
    assign any_req = |req;

    // Lowest-index requester wins; in round-robin mode the lowest requester at or
    // above the pointer overrides it, which gives the wrapping search order.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (req[i]) winner = GW'(i);
        end
        if (ARB_MODE == 0) begin
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (req[i] && (GW'(i) >= rr_ptr_q)) winner = GW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ch_rdata_d  = ch_rdata_q;
        ch_ready_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = winner;
                    if (ARB_MODE == 0) begin
                        rr_ptr_d = (winner == GW'(NUM_CH - 1)) ? '0 : winner + 1'b1;
                    end
                    // A simultaneous read and write is treated as a write.
                    mem_write_d = ch_write[winner];
                    mem_read_d  = ch_read[winner] & ~ch_write[winner];
                    mem_addr_d  = addr_arr[winner];
                    mem_wdata_d = wdata_arr[winner];
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    ch_rdata_d  = mem_rdata;
                    ch_ready_d  = NUM_CH'(1) << grant_q;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ch_rdata_q  <= '0;
            ch_ready_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ch_rdata_q  <= ch_rdata_d;
            ch_ready_q  <= ch_ready_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ch_rdata  = ch_rdata_q;
    assign ch_ready  = ch_ready_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiter instances (2ch RR, 2ch fixed, 3ch RR), each with
// a fixed-latency memory model; expected transfers are queued, a monitor checks them.
module tb_mem_port_arbiter;

    localparam int NDUT    = 3;
    localparam int MEM_LAT = 5;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D10 = 128'h00000010_00000010_00000010_00000010;
    localparam logic [127:0] D20 = 128'h00000020_00000020_00000020_00000020;
    localparam logic [127:0] D30 = 128'h00000030_00000030_00000030_00000030;
    localparam logic [127:0] D40 = 128'h00000040_00000040_00000040_00000040;
    localparam logic [127:0] D50 = 128'h00000050_00000050_00000050_00000050;
    localparam logic [127:0] D60 = 128'h00000060_00000060_00000060_00000060;
    localparam logic [127:0] D70 = 128'h00000070_00000070_00000070_00000070;
    localparam logic [127:0] D80 = 128'h00000080_00000080_00000080_00000080;
    localparam logic [127:0] W1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] W2  = 128'hFEDCBA9876543210FEDCBA9876543210;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]     rd     [NDUT];
    logic [2:0]     wr     [NDUT];
    logic [83:0]    addr   [NDUT];
    logic [383:0]   wdata  [NDUT];
    logic [2:0]     rdy    [NDUT];
    logic [127:0]   crdata [NDUT];
    logic           mrd    [NDUT];
    logic           mwr    [NDUT];
    logic [27:0]    maddr  [NDUT];
    logic [127:0]   mwdata [NDUT];
    logic [1:0]     gid    [NDUT];
    logic           busyv  [NDUT];
    logic           mrdy_v [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int unsigned NC  = (k == 2) ? 3 : 2;
        localparam int unsigned AM  = (k == 1) ? 1 : 0;
        localparam int unsigned GWL = (k == 2) ? 2 : 1;
        logic [NC-1:0]  ready_w;
        logic [GWL-1:0] gid_w;
        logic [127:0]   rdata_w, wd_w, mem_rdata;
        logic [27:0]    addr_w;
        logic           rd_w, wr_w, busy_w, mem_ready;
        int             cnt;

        mem_port_arbiter #(.NUM_CH(NC), .AW(28), .DW(128), .ARB_MODE(AM)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ch_read   (rd[k][NC-1:0]),
            .ch_write  (wr[k][NC-1:0]),
            .ch_addr   (addr[k][NC*28-1:0]),
            .ch_wdata  (wdata[k][NC*128-1:0]),
            .ch_rdata  (rdata_w),
            .ch_ready  (ready_w),
            .mem_read  (rd_w),
            .mem_write (wr_w),
            .mem_addr  (addr_w),
            .mem_wdata (wd_w),
            .mem_rdata (mem_rdata),
            .mem_ready (mem_ready),
            .grant_id  (gid_w),
            .busy      (busy_w)
        );

        assign rdy[k]    = 3'(ready_w);
        assign gid[k]    = 2'(gid_w);
        assign crdata[k] = rdata_w;
        assign mrd[k]    = rd_w;
        assign mwr[k]    = wr_w;
        assign maddr[k]  = addr_w;
        assign mwdata[k] = wd_w;
        assign busyv[k]  = busy_w;
        assign mrdy_v[k] = mem_ready;

        assign mem_rdata = (addr_w == 28'h0000123) ? DA5 : {4{4'h0, addr_w}};

        // Memory answers MEM_LAT cycles after a request appears.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt       <= 0;
                mem_ready <= 1'b0;
            end else begin
                mem_ready <= 1'b0;
                if ((rd_w || wr_w) && !mem_ready) begin
                    if (cnt == MEM_LAT - 1) begin
                        mem_ready <= 1'b1;
                        cnt       <= 0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
            end
        end
    end

    typedef struct {
        int           dut;
        int           ch;
        logic [127:0] data;
        bit           is_wr;
    } cexp_t;

    typedef struct {
        int           dut;
        logic [27:0]  addr;
        bit           is_wr;
        logic [127:0] wdata;
    } mexp_t;

    cexp_t cq[$];
    mexp_t mq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory-side request order/contents/stability and channel completions.
    initial begin : monitor
        logic         prev_req  [NDUT];
        logic         prev_mrdy [NDUT];
        logic [27:0]  hold_addr [NDUT];
        logic [127:0] hold_wd   [NDUT];
        logic         hold_rd   [NDUT];
        logic         hold_wr   [NDUT];
        logic         req;
        mexp_t        m;
        cexp_t        c;
        for (int k = 0; k < NDUT; k++) begin
            prev_req[k]  = 1'b0;
            prev_mrdy[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                req = mrd[k] | mwr[k];
                if (req && !prev_req[k]) begin
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_req_unexpected: dut %0d addr %h, expected none",
                                 k, maddr[k]);
                    end else begin
                        m = mq.pop_front();
                        check("mem_dut", k, m.dut);
                        check("mem_addr", maddr[k], m.addr);
                        check("mem_write", mwr[k], m.is_wr);
                        check("mem_read", mrd[k], !m.is_wr);
                        if (m.is_wr) check("mem_wdata", mwdata[k], m.wdata);
                    end
                    hold_addr[k] = maddr[k];
                    hold_wd[k]   = mwdata[k];
                    hold_rd[k]   = mrd[k];
                    hold_wr[k]   = mwr[k];
                end else if (req && prev_req[k]) begin
                    check("mem_addr_stable", maddr[k], hold_addr[k]);
                    check("mem_wdata_stable", mwdata[k], hold_wd[k]);
                    check("mem_read_stable", mrd[k], hold_rd[k]);
                    check("mem_write_stable", mwr[k], hold_wr[k]);
                end
                if (rdy[k] != 3'b000) begin
                    if (cq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ch_ready_unexpected: dut %0d ready %b, expected none",
                                 k, rdy[k]);
                    end else begin
                        c = cq.pop_front();
                        check("ready_dut", k, c.dut);
                        check("ch_ready", rdy[k], 3'b001 << c.ch);
                        check("grant_id", gid[k], c.ch);
                        if (!c.is_wr) check("ch_rdata", crdata[k], c.data);
                        check("ready_after_mem_ready", prev_mrdy[k], 1);
                        check("release_busy", busyv[k], 1);
                        check("release_mem_idle", req, 0);
                    end
                end
                prev_req[k]  = req;
                prev_mrdy[k] = mrdy_v[k];
            end
        end
    end

    task automatic wait_ready(input int k, input int ch);
        int n = 0;
        while (rdy[k][ch] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: dut %0d ch %0d got no ch_ready, expected a pulse", k, ch);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            rd[k] = '0;
            wr[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic cexp_t ce(input int dut, input int ch, input logic [127:0] d,
                                 input bit w);
        cexp_t e;
        e.dut = dut; e.ch = ch; e.data = d; e.is_wr = w;
        return e;
    endfunction

    function automatic mexp_t me(input int dut, input logic [27:0] a, input bit w,
                                 input logic [127:0] d);
        mexp_t e;
        e.dut = dut; e.addr = a; e.is_wr = w; e.wdata = d;
        return e;
    endfunction

    initial begin : stim
        for (int k = 0; k < NDUT; k++) begin
            rd[k] = '0; wr[k] = '0; addr[k] = '0; wdata[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ch_ready", rdy[k], 0);
            check("rst_ch_rdata", crdata[k], 0);
            check("rst_mem_read", mrd[k], 0);
            check("rst_mem_write", mwr[k], 0);
            check("rst_mem_addr", maddr[k], 0);
            check("rst_mem_wdata", mwdata[k], 0);
            check("rst_grant_id", gid[k], 0);
            check("rst_busy", busyv[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on ch0.
        addr[0][27:0] = 28'h0000123;
        rd[0] = 3'b001;
        mq.push_back(me(0, 28'h0000123, 1'b0, '0));
        cq.push_back(ce(0, 0, DA5, 1'b0));
        @(posedge clk); #1;
        check("single_mem_read_t1", mrd[0], 1);
        check("single_mem_addr_t1", maddr[0], 28'h0000123);
        check("single_busy_t1", busyv[0], 1);
        wait_ready(0, 0);
        rd[0] = '0;
        repeat (3) @(negedge clk);

        // Round-robin contention, both held for six transfers.
        do_reset();
        addr[0][27:0]  = 28'h10;
        addr[0][55:28] = 28'h20;
        rd[0] = 3'b011;
        for (int i = 0; i < 6; i++) begin
            mq.push_back(me(0, (i % 2 == 0) ? 28'h10 : 28'h20, 1'b0, '0));
            cq.push_back(ce(0, i % 2, (i % 2 == 0) ? D10 : D20, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            wait_ready(0, i % 2);
            if (i == 5) rd[0] = '0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Fixed priority: ch1 only wins once ch0 goes quiet.
        do_reset();
        addr[1][27:0]  = 28'h30;
        addr[1][55:28] = 28'h40;
        rd[1] = 3'b011;
        mq.push_back(me(1, 28'h30, 1'b0, '0)); cq.push_back(ce(1, 0, D30, 1'b0));
        mq.push_back(me(1, 28'h30, 1'b0, '0)); cq.push_back(ce(1, 0, D30, 1'b0));
        mq.push_back(me(1, 28'h40, 1'b0, '0)); cq.push_back(ce(1, 1, D40, 1'b0));
        wait_ready(1, 0);
        @(negedge clk);
        wait_ready(1, 0);
        rd[1][0] = 1'b0;
        @(negedge clk);
        wait_ready(1, 1);
        rd[1] = '0;
        repeat (3) @(negedge clk);

        // Write on ch1 while ch0 wiggles its request during BUSY.
        do_reset();
        addr[0][55:28]   = 28'h00000FF;
        wdata[0][255:128] = W1;
        wr[0] = 3'b010;
        mq.push_back(me(0, 28'h00000FF, 1'b1, W1));
        cq.push_back(ce(0, 1, '0, 1'b1));
        @(posedge clk); #1;
        check("write_mem_write_t1", mwr[0], 1);
        check("write_mem_read_t1", mrd[0], 0);
        @(negedge clk);
        rd[0][0] = 1'b1;
        addr[0][27:0] = 28'h0ABCDEF;
        @(negedge clk);
        rd[0][0] = 1'b0;
        wdata[0][127:0] = W2;
        wait_ready(0, 1);
        wr[0] = '0;
        repeat (3) @(negedge clk);

        // Reset two cycles into BUSY, then check the pointer restarted at 0.
        do_reset();
        addr[0][27:0]  = 28'h50;
        addr[0][55:28] = 28'h60;
        rd[0] = 3'b001;
        mq.push_back(me(0, 28'h50, 1'b0, '0));
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd[0] = '0;
        #1;
        check("abort_mem_read", mrd[0], 0);
        check("abort_mem_addr", maddr[0], 0);
        check("abort_busy", busyv[0], 0);
        check("abort_ch_ready", rdy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd[0] = 3'b011;
        mq.push_back(me(0, 28'h50, 1'b0, '0)); cq.push_back(ce(0, 0, D50, 1'b0));
        mq.push_back(me(0, 28'h60, 1'b0, '0)); cq.push_back(ce(0, 1, D60, 1'b0));
        wait_ready(0, 0);
        rd[0][0] = 1'b0;
        @(negedge clk);
        wait_ready(0, 1);
        rd[0] = '0;
        repeat (3) @(negedge clk);

        // Three channels, wrap-around; ch2 raises read and write together.
        do_reset();
        addr[2][27:0]     = 28'h70;
        addr[2][55:28]    = 28'h80;
        addr[2][83:56]    = 28'h90;
        wdata[2][383:256] = W2;
        rd[2] = 3'b111;
        wr[2] = 3'b100;
        for (int r = 0; r < 2; r++) begin
            mq.push_back(me(2, 28'h70, 1'b0, '0)); cq.push_back(ce(2, 0, D70, 1'b0));
            mq.push_back(me(2, 28'h80, 1'b0, '0)); cq.push_back(ce(2, 1, D80, 1'b0));
            mq.push_back(me(2, 28'h90, 1'b1, W2)); cq.push_back(ce(2, 2, '0, 1'b1));
        end
        for (int i = 0; i < 6; i++) begin
            wait_ready(2, i % 3);
            if (i == 5) begin
                rd[2] = '0;
                wr[2] = '0;
            end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);

        check("completions_left", cq.size(), 0);
        check("mem_requests_left", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
